// File: rtl/fp32_seq_multiplier_pkg.sv
// rtl/fp32_seq_multiplier_pkg.sv - shared binary32 constants, operand types and FSM state codes
// Purpose: common definitions for the multiplier and its operand classifier, reusable by the
//          adder and divider. No ports.
package fp32_pkg;

   localparam int          XLEN       = 32;
   localparam int          MAN_W      = 23;
   localparam int          EXP_W      = 8;
   localparam int          FP_BIAS    = 127;
   localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
   localparam logic [7:0]  FP_INF_EXP = 8'hFF;

   // FSM state codes
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_UNPACK = 3'd1;
   localparam logic [2:0] S_MUL    = 3'd2;
   localparam logic [2:0] S_NORM   = 3'd3;
   localparam logic [2:0] S_ROUND  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORMAL,
      CLS_INF,
      CLS_NAN
   } fp_class_e;

   typedef struct packed {
      logic            sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W:0]  sig;   // hidden bit included; zero for the ZERO class
      fp_class_e       cls;
   } fp_unpacked_t;

endpackage

// File: rtl/fp32_seq_multiplier_if.sv
// rtl/fp32_seq_multiplier_if.sv - operand/result handshake bundle for the sequential multiplier
// Purpose: groups the input (in_valid/in_ready/A/B) and output (out_valid/out_ready/result/flags)
//          handshakes. master = producer/consumer side, slave = multiplier side.
interface fp32_seq_multiplier_if;

   logic                      in_valid;
   logic                      in_ready;
   logic [fp32_pkg::XLEN-1:0] A;
   logic [fp32_pkg::XLEN-1:0] B;
   logic                      out_valid;
   logic                      out_ready;
   logic [fp32_pkg::XLEN-1:0] result;
   logic                      overflow;
   logic                      underflow;
   logic                      exception;

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, result, overflow, underflow, exception
   );

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, result, overflow, underflow, exception
   );

endinterface

// File: rtl/fp32_seq_multiplier_classify.sv
// rtl/fp32_seq_multiplier_classify.sv - combinational binary32 operand unpack and classify
// Purpose: splits an operand into sign, biased exponent and 24-bit significand and classifies it.
// Ports:   op_i  - binary32 operand
//          unp_o - {sign, exp, significand, class}; denormals are reported as ZERO
module fp32_classify
   import fp32_pkg::*;
(
   input  logic [XLEN-1:0] op_i,
   output fp_unpacked_t    unp_o
);

   always_comb begin
      unp_o.sign = op_i[31];
      unp_o.exp  = op_i[30:23];
      unp_o.sig  = {1'b1, op_i[22:0]};
      unp_o.cls  = CLS_NORMAL;
      if (op_i[30:23] == FP_INF_EXP) begin
         unp_o.cls = (op_i[22:0] != '0) ? CLS_NAN : CLS_INF;
      end else if (op_i[30:23] == '0) begin
         // denormals are flushed to zero on input
         unp_o.cls = CLS_ZERO;
         unp_o.sig = '0;
      end
   end

endmodule

// File: rtl/fp32_seq_multiplier.sv
// rtl/fp32_seq_multiplier.sv - multi-cycle binary32 multiplier, radix-2 shift-add, RNE rounding
// Purpose: computes A*B with one multiplier bit per cycle. Specials finish one cycle after accept,
//          normal operands 27 cycles after accept.
// Ports:   clk   - rising-edge clock
//          rst_n - asynchronous active-low reset
//          bus   - slave side of fp32_seq_multiplier_if (operand and result handshakes, flags)
module fp32_seq_multiplier
   import fp32_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   fp32_seq_multiplier_if.slave bus
);

   logic [2:0]        state_q,  state_d;
   logic [XLEN-1:0]   a_q,      a_d;
   logic [XLEN-1:0]   b_q,      b_d;
   logic              sign_q,   sign_d;
   logic signed [9:0] exp_q,    exp_d;
   logic [47:0]       mcand_q,  mcand_d;
   logic [23:0]       mplier_q, mplier_d;
   logic [47:0]       prod_q,   prod_d;
   logic [4:0]        cnt_q,    cnt_d;
   logic [22:0]       mant_q,   mant_d;
   logic              guard_q,  guard_d;
   logic              sticky_q, sticky_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              ovf_q,    ovf_d;
   logic              unf_q,    unf_d;
   logic              exc_q,    exc_d;

   fp_unpacked_t      un_a, un_b;
   logic              any_nan, any_inf, any_zero, inf_times_zero;
   logic              round_up, carry;
   logic [22:0]       mant_r;
   logic signed [9:0] exp_r;

   fp32_classify u_cls_a (.op_i(a_q), .unp_o(un_a));
   fp32_classify u_cls_b (.op_i(b_q), .unp_o(un_b));

   assign any_nan        = (un_a.cls == CLS_NAN)  || (un_b.cls == CLS_NAN);
   assign any_inf        = (un_a.cls == CLS_INF)  || (un_b.cls == CLS_INF);
   assign any_zero       = (un_a.cls == CLS_ZERO) || (un_b.cls == CLS_ZERO);
   assign inf_times_zero = any_inf && any_zero;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      mant_d   = mant_q;
      guard_d  = guard_q;
      sticky_d = sticky_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      exc_d    = exc_q;
      round_up = 1'b0;
      carry    = 1'b0;
      mant_r   = '0;
      exp_r    = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.A;
               b_d     = bus.B;
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               exc_d   = 1'b0;
               state_d = S_UNPACK;
            end
         end

         S_UNPACK: begin
            sign_d   = un_a.sign ^ un_b.sign;
            exp_d    = $signed({2'b00, un_a.exp}) + $signed({2'b00, un_b.exp}) - 10'(FP_BIAS);
            mcand_d  = {24'd0, un_a.sig};
            mplier_d = un_b.sig;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
            // NaN beats Inf beats zero; Inf*0 is invalid and joins the NaN case
            if (any_nan || inf_times_zero) begin
               result_d = FP_QNAN;
               exc_d    = 1'b1;
               state_d  = S_DONE;
            end else if (any_inf) begin
               result_d = {sign_d, FP_INF_EXP, 23'd0};
               state_d  = S_DONE;
            end else if (any_zero) begin
               result_d = {sign_d, 31'd0};
               state_d  = S_DONE;
            end
         end

         S_MUL: begin
            // LSB-first: the multiplicand walks left while the multiplier walks right
            if (mplier_q[0]) begin
               prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == 5'd23) begin
               cnt_d   = '0;
               state_d = S_NORM;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end

         S_NORM: begin
            // product of two [1,2) significands lies in [1,4): at most one right shift
            if (prod_q[47]) begin
               mant_d   = prod_q[46:24];
               guard_d  = prod_q[23];
               sticky_d = |prod_q[22:0];
               exp_d    = exp_q + 10'sd1;
            end else begin
               mant_d   = prod_q[45:23];
               guard_d  = prod_q[22];
               sticky_d = |prod_q[21:0];
            end
            state_d = S_ROUND;
         end

         S_ROUND: begin
            round_up        = guard_q && (sticky_q || mant_q[0]);
            {carry, mant_r} = {1'b0, mant_q} + 24'(round_up);
            // a carry out means 1.111..1 rounded to 10.000..0: the mantissa field is already zero
            exp_r           = carry ? (exp_q + 10'sd1) : exp_q;
            if (exp_r >= 10'sd255) begin
               result_d = {sign_q, FP_INF_EXP, 23'd0};
               ovf_d    = 1'b1;
            end else if (exp_r <= 10'sd0) begin
               result_d = {sign_q, 31'd0};
               unf_d    = 1'b1;
            end else begin
               result_d = {sign_q, exp_r[7:0], mant_r};
            end
            state_d = S_DONE;
         end

         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         mant_q   <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         mant_q   <= mant_d;
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         exc_q    <= exc_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.result    = result_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
   assign bus.exception = exc_q;

endmodule

// File: tb/tb_fp32_seq_multiplier.sv
// tb/tb_fp32_seq_multiplier.sv - self-checking bench for fp32_seq_multiplier
module tb_fp32_seq_multiplier;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [2:0]  f;     // {overflow, underflow, exception}
      logic [7:0]  lat;
   } vec_t;

   typedef struct packed {
      logic [31:0] r;
      logic [2:0]  f;
      logic [7:0]  lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   fp32_seq_multiplier_if bus ();

   fp32_seq_multiplier dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   function automatic logic [31:0] flags();
      return {29'd0, bus.overflow, bus.underflow, bus.exception};
   endfunction

   // Reference: exact integer product, then round to nearest even by comparing the discarded
   // remainder against half an ulp.
   function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int ea, eb, ex, sh;
      logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      longint unsigned p, q, rem, half;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s = a[31] ^ b[31];
      a_nan = (ea == 255) && (a[22:0] != 0);
      b_nan = (eb == 255) && (b[22:0] != 0);
      a_inf = (ea == 255) && (a[22:0] == 0);
      b_inf = (eb == 255) && (b[22:0] == 0);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      e.f = 3'b000;
      e.lat = 8'd1;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         e.r = 32'h7FC00000;
         e.f = 3'b001;
      end else if (a_inf || b_inf) begin
         e.r = {s, 8'hFF, 23'd0};
      end else if (a_zero || b_zero) begin
         e.r = {s, 31'd0};
      end else begin
         e.lat = 8'd27;
         p = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
         ex = ea + eb - 127;
         if (p >= (64'd1 << 47)) begin
            sh = 24;
            ex = ex + 1;
         end else begin
            sh = 23;
         end
         q = p >> sh;
         rem = p & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 64'd1;
         if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            ex = ex + 1;
         end
         if (ex >= 255) begin
            e.r = {s, 8'hFF, 23'd0};
            e.f = 3'b100;
         end else if (ex <= 0) begin
            e.r = {s, 31'd0};
            e.f = 3'b010;
         end else begin
            e.r = {s, 8'(ex), q[22:0]};
         end
      end
      return e;
   endfunction

   // Waits for out_valid for at most lim edges; returns edges counted.
   task automatic wait_out(input int lim, output int n);
      n = 0;
      while (!bus.out_valid && n < lim) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   // Called #1 after a posedge with the DUT idle.
   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [2:0] ef, input int elat);
      int n;
      chk({nm, " in_ready idle"}, {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.A = a;
      bus.B = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk({nm, " in_ready busy"}, {31'd0, bus.in_ready}, 32'd0);
      wait_out(100, n);
      chk({nm, " latency"}, 32'(n), 32'(elat));
      chk({nm, " result"}, bus.result, er);
      chk({nm, " flags"}, flags(), {29'd0, ef});
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({nm, " out_valid drop"}, {31'd0, bus.out_valid}, 32'd0);
   endtask

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      int k;
      k = int'($urandom_range(0, 15));
      v = $urandom;
      case (k)
         0: v[30:0] = 31'd0;
         1: v[30:0] = {8'hFF, 23'd0};
         2: v[30:23] = 8'hFF;
         3: v[30:23] = 8'h00;
         4: v[30:23] = 8'($urandom_range(1, 254));
         default: v[30:23] = 8'($urandom_range(64, 190));
      endcase
      return v;
   endfunction

   vec_t vt[12];

   initial begin
      int n;
      exp_t e;
      logic [31:0] ra, rb;

      vt[0]  = '{32'h40400000, 32'h40000000, 32'h40C00000, 3'b000, 8'd27};
      vt[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 8'd27};
      vt[2]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 8'd27};
      vt[3]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100, 8'd27};
      vt[4]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, 8'd27};
      vt[5]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b001, 8'd1};
      vt[6]  = '{32'h7F800000, 32'h80000000, 32'h7FC00000, 3'b001, 8'd1};
      vt[7]  = '{32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 8'd1};
      vt[8]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000, 8'd27};
      vt[9]  = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000, 8'd27};
      vt[10] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000, 8'd1};
      vt[11] = '{32'h00000001, 32'h40000000, 32'h00000000, 3'b000, 8'd1};

      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.A = '0;
      bus.B = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset result", bus.result, 32'd0);
      chk("reset flags", flags(), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].r, vt[i].f, int'(vt[i].lat));
      end

      for (int i = 0; i < 40; i++) begin
         ra = rand_op();
         rb = rand_op();
         e = ref_mul(ra, rb);
         run_op($sformatf("rnd%0d %h*%h", i, ra, rb), ra, rb, e.r, e.f, int'(e.lat));
      end

      // Back-pressure: result held, no accept while busy, then transfer with in_valid still high
      bus.in_valid = 1'b1;
      bus.A = 32'h40400000;
      bus.B = 32'h40000000;
      @(posedge clk);
      #1;
      bus.A = 32'h3FC00000;
      bus.B = 32'h3FC00000;
      wait_out(100, n);
      chk("hold latency", 32'(n), 32'd27);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("hold%0d result", i), bus.result, 32'h40C00000);
         chk($sformatf("hold%0d state", i),
             {28'd0, bus.out_valid, bus.in_ready, bus.overflow | bus.underflow, bus.exception},
             32'h8);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("xfer out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("xfer in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("second accept", {31'd0, bus.in_ready}, 32'd0);
      wait_out(100, n);
      chk("second latency", 32'(n), 32'd27);
      chk("second result", bus.result, 32'h40100000);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;

      // Reset while the multiply loop is at iteration 12
      bus.in_valid = 1'b1;
      bus.A = 32'h40400000;
      bus.B = 32'h40000000;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("abort result", bus.result, 32'd0);
      chk("abort flags", flags(), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("no residual", {31'd0, bus.out_valid}, 32'd0);
      run_op("after reset", 32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 27);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
